// File: rtl/ping_pong_merge.sv
// ping_pong_merge
//
// Recombines the two lane streams of a ping-pong splitter into one ordered
// stream. Words are taken strictly alternately: A0, B0, A1, B1, ...
// Each lane has its own FIFO, so the upstream lane processors may have
// unequal latency. The merged stream leaves through a registered
// valid/ready output stage.
//
// Optional feature: define PING_PONG_MERGE_TIMEOUT_EN to build a watchdog.
// The watchdog counts while the expected lane is empty and the other lane
// is full. When it reaches TIMEOUT it sets the sticky err flag and flips
// phase to the starved-but-full lane. Without the macro, err is tied low
// and the merge waits for the expected lane forever.
//
// Parameters
//   DATA_W   width of each data word
//   DEPTH    entries per lane FIFO (power of 2, >= 2)
//   TIMEOUT  watchdog limit in cycles (watchdog build only)
//
// Ports
//   clk                   system clock
//   reset                 asynchronous active-low reset
//   inA_valid/data/ready  lane A input handshake (ready = FIFO A not full)
//   inB_valid/data/ready  lane B input handshake (ready = FIFO B not full)
//   out_valid/data/ready  merged output handshake (registered)
//   phase                 lane expected next: 0 = A, 1 = B
//   merge_cnt             count of delivered words, wraps at 16 bits
//   err                   sticky watchdog error
module ping_pong_merge #(
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inA_valid,
   input  logic [DATA_W-1:0] inA_data,
   output logic              inA_ready,
   input  logic              inB_valid,
   input  logic [DATA_W-1:0] inB_data,
   output logic              inB_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              phase,
   output logic [15:0]       merge_cnt,
   output logic              err
);

   localparam int AW = $clog2(DEPTH);
   // One extra pointer bit separates "full" from "empty" when the
   // index bits match.
   localparam int PW = AW + 1;

   typedef enum logic {
      LANE_A = 1'b0,
      LANE_B = 1'b1
   } lane_e;

   // Lane index 0 = A, 1 = B.
   logic [1:0]        lane_valid;
   logic [1:0]        lane_full;
   logic [1:0]        lane_empty;
   logic [1:0]        lane_pop;
   logic [DATA_W-1:0] lane_data [2];
   logic [DATA_W-1:0] lane_head [2];

   assign lane_valid   = {inB_valid, inA_valid};
   assign lane_data[0] = inA_data;
   assign lane_data[1] = inB_data;

   // Output stage state.
   lane_e             phase_reg, phase_next;
   logic              out_valid_reg, out_valid_next;
   logic [DATA_W-1:0] out_data_reg, out_data_next;
   logic [15:0]       merge_cnt_reg, merge_cnt_next;

   logic              sel_idx;
   logic              sel_empty;
   logic              load;
   logic              pop;
   logic              wd_fire;

   // -------------------------------------------------------------------
   // Lane FIFOs
   // -------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [DATA_W-1:0] mem [DEPTH];
         logic [PW-1:0]     wr_ptr_reg;
         logic [PW-1:0]     rd_ptr_reg;
         logic              push;

         // Ready is !full, so a full FIFO never takes a write, even when
         // it is popped in the same cycle.
         assign push = lane_valid[gi] && !lane_full[gi];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else begin
               if (push) begin
                  wr_ptr_reg <= wr_ptr_reg + PW'(1);
               end
               if (lane_pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + PW'(1);
               end
            end
         end

         // Storage has no reset; the pointers alone define its contents.
         always_ff @(posedge clk) begin
            if (push) begin
               mem[wr_ptr_reg[AW-1:0]] <= lane_data[gi];
            end
         end

         assign lane_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
         assign lane_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
         assign lane_head[gi]  = mem[rd_ptr_reg[AW-1:0]];
         // Only the lane that phase selects is ever popped. This keeps
         // the output in order.
         assign lane_pop[gi]   = pop && (sel_idx == 1'(gi));
      end
   endgenerate

   assign inA_ready = !lane_full[0];
   assign inB_ready = !lane_full[1];

   // -------------------------------------------------------------------
   // Output register / phase control
   // -------------------------------------------------------------------
   assign sel_idx   = (phase_reg == LANE_B);
   assign sel_empty = lane_empty[sel_idx];
   assign load      = !out_valid_reg || out_ready;
   assign pop       = load && !sel_empty;

   always_comb begin
      phase_next     = phase_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      merge_cnt_next = merge_cnt_reg;

      if (load) begin
         if (pop) begin
            out_valid_next = 1'b1;
            out_data_next  = lane_head[sel_idx];
            phase_next     = (phase_reg == LANE_A) ? LANE_B : LANE_A;
         end else begin
            // out_data keeps its last value.
            out_valid_next = 1'b0;
         end
      end

      // The watchdog only fires while the selected lane is empty.
      // Pop is therefore low, and the two phase updates never collide.
      if (wd_fire) begin
         phase_next = (phase_reg == LANE_A) ? LANE_B : LANE_A;
      end

      if (out_valid_reg && out_ready) begin
         merge_cnt_next = merge_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_reg     <= LANE_A;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         merge_cnt_reg <= '0;
      end else begin
         phase_reg     <= phase_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         merge_cnt_reg <= merge_cnt_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign phase     = (phase_reg == LANE_B);
   assign merge_cnt = merge_cnt_reg;

   // -------------------------------------------------------------------
   // Optional watchdog
   // -------------------------------------------------------------------
`ifdef PING_PONG_MERGE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_reg, wd_next;
   logic            err_reg, err_next;
   logic            wd_cond;

   // Deadlock signature: the expected lane is empty and the other lane
   // is full, so it cannot accept anything more.
   assign wd_cond = sel_empty && lane_full[!sel_idx];

   always_comb begin
      wd_next  = '0;
      wd_fire  = 1'b0;
      err_next = err_reg;
      if (wd_cond) begin
         // The count reaches TIMEOUT on this edge.
         if (wd_reg == WD_W'(TIMEOUT - 1)) begin
            wd_fire  = 1'b1;
            err_next = 1'b1;
         end else begin
            wd_next = wd_reg + WD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_reg  <= '0;
         err_reg <= 1'b0;
      end else begin
         wd_reg  <= wd_next;
         err_reg <= err_next;
      end
   end

   assign err = err_reg;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign wd_fire        = 1'b0;
   assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_ping_pong_merge.sv
module tb_ping_pong_merge;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
`ifdef PING_PONG_MERGE_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          inA_valid = 1'b0;
   logic [DW-1:0] inA_data = '0;
   logic          inA_ready;
   logic          inB_valid = 1'b0;
   logic [DW-1:0] inB_data = '0;
   logic          inB_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          phase;
   logic [15:0]   merge_cnt;
   logic          err;

   ping_pong_merge #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .inA_valid(inA_valid), .inA_data(inA_data), .inA_ready(inA_ready),
      .inB_valid(inB_valid), .inB_data(inB_data), .inB_ready(inB_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .phase(phase), .merge_cnt(merge_cnt), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model: two queues + output slot -------
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   bit            ov_m  = 1'b0;
   logic [DW-1:0] od_m  = '0;
   bit            ph_m  = 1'b0;
   logic [15:0]   cnt_m = '0;
   bit            err_m = 1'b0;
   int            wd_m  = 0;
   int            sa, sb;
   bit            ld_m, hs_m, ph_old;

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            qa.delete();
            qb.delete();
            ov_m  = 1'b0;
            od_m  = '0;
            ph_m  = 1'b0;
            cnt_m = '0;
            err_m = 1'b0;
            wd_m  = 0;
         end else begin
            sa     = qa.size();
            sb     = qb.size();
            ph_old = ph_m;
            hs_m   = ov_m && out_ready;
            ld_m   = !ov_m || out_ready;
            if (hs_m) begin
               $display("[TB] xfer %0d data=%h", cnt_m, od_m);
               cnt_m = cnt_m + 16'd1;
            end
            if (ld_m) begin
               if (!ph_m && sa > 0) begin
                  od_m = qa.pop_front(); ov_m = 1'b1; ph_m = 1'b1;
               end else if (ph_m && sb > 0) begin
                  od_m = qb.pop_front(); ov_m = 1'b1; ph_m = 1'b0;
               end else begin
                  ov_m = 1'b0;
               end
            end
`ifdef PING_PONG_MERGE_TIMEOUT_EN
            if ((!ph_old && sa == 0 && sb == DEPTH) || (ph_old && sb == 0 && sa == DEPTH)) begin
               wd_m++;
               if (wd_m == TMO) begin
                  err_m = 1'b1;
                  ph_m  = !ph_m;
                  wd_m  = 0;
               end
            end else begin
               wd_m = 0;
            end
`endif
            if (inA_valid && sa < DEPTH) qa.push_back(inA_data);
            if (inB_valid && sb < DEPTH) qb.push_back(inB_data);
         end
      end
   end

   // ---------------- cycle-by-cycle compare against the model ----------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            chk("m_out_valid", 32'(out_valid), 32'(ov_m));
            chk("m_out_data",  32'(out_data),  32'(od_m));
            chk("m_phase",     32'(phase),     32'(ph_m));
            chk("m_merge_cnt", 32'(merge_cnt), 32'(cnt_m));
            chk("m_inA_ready", 32'(inA_ready), 32'(qa.size() < DEPTH));
            chk("m_inB_ready", 32'(inB_ready), 32'(qb.size() < DEPTH));
            chk("m_err",       32'(err),       32'(err_m));
         end
      end
   end

   // ---------------- stimulus helpers ----------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inA_valid = 1'b0;
      inB_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      step();
   endtask

   task automatic drain(input int n);
      idle_inputs();
      out_ready = 1'b1;
      repeat (n) step();
   endtask

   initial begin
      // Reset then idle
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      step();
      chk("rst_inA_ready", 32'(inA_ready), 32'd1);
      chk("rst_inB_ready", 32'(inB_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_phase",     32'(phase),     32'd0);
      chk("rst_merge_cnt", 32'(merge_cnt), 32'd0);
      chk("rst_err",       32'(err),       32'd0);

      // Ordered merge
      out_ready = 1'b1;
      inA_valid = 1'b1; inA_data = 16'h0001;
      inB_valid = 1'b1; inB_data = 16'h0002;
      step();
      inA_data = 16'h0003; inB_data = 16'h0004;
      step();
      chk("ord_first_valid", 32'(out_valid), 32'd1);
      chk("ord_data0", 32'(out_data), 32'h0001);
      idle_inputs();
      step(); chk("ord_data1", 32'(out_data), 32'h0002);
      step(); chk("ord_data2", 32'(out_data), 32'h0003);
      step(); chk("ord_data3", 32'(out_data), 32'h0004);
      step();
      chk("ord_valid_end", 32'(out_valid), 32'd0);
      chk("ord_cnt", 32'(merge_cnt), 32'd4);

      // Skewed lanes: B fills before A sends anything
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inB_valid = 1'b1; inB_data = 16'h0020 + 16'(i);
         step();
      end
      idle_inputs();
      chk("skew_inB_full", 32'(inB_ready), 32'd0);
      chk("skew_no_valid", 32'(out_valid), 32'd0);
      inA_valid = 1'b1; inA_data = 16'h0010;
      step();
      idle_inputs();
      step();
      chk("skew_a0", 32'(out_data), 32'h0010);
      chk("skew_phase", 32'(phase), 32'd1);
      chk("skew_b_still_full", 32'(inB_ready), 32'd0);
      step();
      chk("skew_b0", 32'(out_data), 32'h0020);
      chk("skew_b_ready_back", 32'(inB_ready), 32'd1);
      for (int i = 1; i < 4; i++) begin
         inA_valid = 1'b1; inA_data = 16'h0010 + 16'(i);
         step();
      end
      drain(10);

      // Backpressure
      do_reset();
      out_ready = 1'b1;
      inA_valid = 1'b1; inA_data = 16'h0001;
      step();
      idle_inputs();
      step();
      chk("bp_first", 32'(out_data), 32'h0001);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         inA_valid = 1'b1; inA_data = 16'h0100 + 16'(i);
         inB_valid = 1'b1; inB_data = 16'h0200 + 16'(i);
         step();
         chk("bp_hold_data", 32'(out_data), 32'h0001);
         chk("bp_hold_phase", 32'(phase), 32'd1);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      chk("bp_inA_full", 32'(inA_ready), 32'd0);
      chk("bp_inB_full", 32'(inB_ready), 32'd0);
      idle_inputs();
      out_ready = 1'b1;
      step();
      chk("bp_resume_b0", 32'(out_data), 32'h0200);
      drain(12);

      // Reset mid-stream
      do_reset();
      out_ready = 1'b1;
      inA_valid = 1'b1; inA_data = 16'h0030;
      step();
      inA_data = 16'h0031;
      step();
      chk("mid_valid_before", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      inA_data = 16'h0032; step();
      inA_data = 16'h0033; step();
      idle_inputs();
      #1 reset = 1'b0;
      #1 chk("mid_async_drop", 32'(out_valid), 32'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      step();
      chk("mid_inA_ready", 32'(inA_ready), 32'd1);
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_phase", 32'(phase), 32'd0);
      out_ready = 1'b1;
      inA_valid = 1'b1; inA_data = 16'h0055;
      inB_valid = 1'b1; inB_data = 16'h0066;
      step();
      idle_inputs();
      step(); chk("mid_next_a", 32'(out_data), 32'h0055);
      step(); chk("mid_next_b", 32'(out_data), 32'h0066);
      drain(3);

      // Watchdog: B full, A empty, phase 0
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inB_valid = 1'b1; inB_data = 16'h0040 + 16'(i);
         step();
      end
      idle_inputs();
`ifdef PING_PONG_MERGE_TIMEOUT_EN
      begin
         int k = 0;
         while (!err && k < 30) begin
            step();
            k++;
         end
         chk("wd_err_set", 32'(err), 32'd1);
         chk("wd_phase_resync", 32'(phase), 32'd1);
         step();
         chk("wd_b_out", 32'(out_data), 32'h0040);
      end
      drain(10);
`else
      repeat (12) step();
      chk("wd_err_low", 32'(err), 32'd0);
      chk("wd_stalled", 32'(out_valid), 32'd0);
      chk("wd_phase", 32'(phase), 32'd0);
      inA_valid = 1'b1; inA_data = 16'h0070;
      step();
      drain(10);
`endif

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 2500; c++) begin
         inA_valid = ($urandom_range(0, 3) != 0);
         inA_data  = 16'($urandom);
         inB_valid = ($urandom_range(0, 3) != 0);
         inB_data  = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
